// File: rtl/btn_debounce_pkg.sv
// -----------------------------------------------------------------------------
// btn_debounce_pkg
// Shared definitions for the push-button conditioning block:
//   - 2-bit state encodings (BTN_IDLE, BTN_PRESS_WAIT, BTN_PRESSED,
//     BTN_RELEASE_WAIT) and the matching enum type
//   - default filter / long-press cycle counts for the 25 MHz board clock
//   - pin polarity normalisation helper
// -----------------------------------------------------------------------------
package btn_debounce_pkg;

   localparam logic [1:0] BTN_IDLE         = 2'd0;
   localparam logic [1:0] BTN_PRESS_WAIT   = 2'd1;
   localparam logic [1:0] BTN_PRESSED      = 2'd2;
   localparam logic [1:0] BTN_RELEASE_WAIT = 2'd3;

   // 10 ms and 1 s at 25 MHz
   localparam int BTN_DEF_STABLE_CYCLES = 32'd250000;
   localparam int BTN_DEF_LONG_CYCLES   = 32'd25000000;

   typedef enum logic [1:0] {
      ST_IDLE         = BTN_IDLE,
      ST_PRESS_WAIT   = BTN_PRESS_WAIT,
      ST_PRESSED      = BTN_PRESSED,
      ST_RELEASE_WAIT = BTN_RELEASE_WAIT
   } btn_state_e;

   // Maps a raw pin level to "1 = pressed" for either board polarity.
   function automatic logic btn_normalise(input logic pin, input logic active_low);
      return active_low ? ~pin : pin;
   endfunction

endpackage

// File: rtl/btn_debounce_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchroniser for a single asynchronous board input.
// Ports:
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset; both flops load RESET_VAL
//   d      - asynchronous input
//   q      - synchronised output (two clk edges after d is captured)
// RESET_VAL should be the input's idle level so that reset never creates
// a spurious edge downstream.
// -----------------------------------------------------------------------------
module sync2 #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic sync_r;

   // Two-stage capture of the asynchronous input into the clk domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= RESET_VAL;
         sync_r <= RESET_VAL;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Conditions one raw mechanical push-button: synchronise, normalise polarity,
// filter with a consecutive-cycle counter, and emit a clean level plus
// single-cycle press / release / long-press pulses.
// Parameters:
//   ACTIVE_LOW     - 1: pin reads 0 while pressed
//   STABLE_CYCLES  - consecutive stable cycles to accept a change (>= 2)
//   LONG_CYCLES    - press duration that fires long_o (> STABLE_CYCLES)
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   btn_i          - raw button pin, asynchronous to clk
//   level_o        - debounced level, 1 = pressed
//   press_o        - one-cycle pulse on an accepted press
//   release_o      - one-cycle pulse on an accepted release
//   long_o         - one-cycle pulse once per press when the hold reaches
//                    LONG_CYCLES
// All outputs are registered.
// -----------------------------------------------------------------------------
module btn_debounce
   import btn_debounce_pkg::*;
#(
   parameter logic ACTIVE_LOW    = 1'b1,
   parameter int   STABLE_CYCLES = BTN_DEF_STABLE_CYCLES,
   parameter int   LONG_CYCLES   = BTN_DEF_LONG_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o
);

   localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
   localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

   localparam logic [CNT_W-1:0]  CNT_ZERO     = CNT_W'(0);
   localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_STABLE   = CNT_W'(STABLE_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_ZERO    = HOLD_W'(0);
   localparam logic [HOLD_W-1:0] HOLD_ONE     = HOLD_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_STABLE  = HOLD_W'(STABLE_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LONG    = HOLD_W'(LONG_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LONG_M1 = HOLD_W'(LONG_CYCLES - 1);

   // Released pin level, so reset never looks like a press
   localparam logic PIN_RELEASED = ACTIVE_LOW;

   logic              sync_q_s;
   logic              s_r;
   btn_state_e        state_r;
   btn_state_e        state_nxt_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_nxt_s;
   logic [HOLD_W-1:0] hold_r;
   logic [HOLD_W-1:0] hold_nxt_s;
   logic [HOLD_W-1:0] hold_inc_s;
   logic              long_hit_s;
   logic              level_r;
   logic              level_nxt_s;
   logic              press_r;
   logic              press_nxt_s;
   logic              release_r;
   logic              release_nxt_s;
   logic              long_r;
   logic              long_nxt_s;

   sync2 #(
      .RESET_VAL (PIN_RELEASED)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (btn_i),
      .q     (sync_q_s)
   );

   // Registered polarity-normalised sample (1 = pressed)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_r <= 1'b0;
      end else begin
         s_r <= btn_normalise(sync_q_s, ACTIVE_LOW);
      end
   end

   // Saturating hold counter; long_hit_s marks the step that reaches LONG_CYCLES,
   // which can happen only once per press because the counter then sticks.
   assign hold_inc_s = (hold_r == HOLD_LONG) ? hold_r : (hold_r + HOLD_ONE);
   assign long_hit_s = (hold_r == HOLD_LONG_M1);

   // Next-state, counter and output-pulse decode
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r;
      hold_nxt_s    = hold_r;
      level_nxt_s   = 1'b0;
      press_nxt_s   = 1'b0;
      release_nxt_s = 1'b0;
      long_nxt_s    = 1'b0;

      case (state_r)
         ST_IDLE: begin
            hold_nxt_s = HOLD_ZERO;
            if (s_r) begin
               state_nxt_s = ST_PRESS_WAIT;
               cnt_nxt_s   = CNT_ONE;
            end else begin
               cnt_nxt_s   = CNT_ZERO;
            end
         end

         ST_PRESS_WAIT: begin
            if (!s_r) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = CNT_ZERO;
            end else if (cnt_r == CNT_STABLE) begin
               state_nxt_s = ST_PRESSED;
               cnt_nxt_s   = CNT_ZERO;
               // the filter window already counts towards the hold time
               hold_nxt_s  = HOLD_STABLE;
               press_nxt_s = 1'b1;
               level_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_ONE;
            end
         end

         ST_PRESSED: begin
            level_nxt_s = 1'b1;
            hold_nxt_s  = hold_inc_s;
            // long_o is independent of s_r so a release starting now keeps it
            long_nxt_s  = long_hit_s;
            if (!s_r) begin
               state_nxt_s = ST_RELEASE_WAIT;
               cnt_nxt_s   = CNT_ONE;
            end else begin
               cnt_nxt_s   = CNT_ZERO;
            end
         end

         ST_RELEASE_WAIT: begin
            if (s_r) begin
               state_nxt_s = ST_PRESSED;
               cnt_nxt_s   = CNT_ZERO;
               hold_nxt_s  = hold_inc_s;
               long_nxt_s  = long_hit_s;
               level_nxt_s = 1'b1;
            end else if (cnt_r == CNT_STABLE) begin
               // release wins over a coincident long hit: pulses stay exclusive
               state_nxt_s   = ST_IDLE;
               cnt_nxt_s     = CNT_ZERO;
               hold_nxt_s    = HOLD_ZERO;
               release_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_ONE;
               hold_nxt_s  = hold_inc_s;
               long_nxt_s  = long_hit_s;
               level_nxt_s = 1'b1;
            end
         end

         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
            hold_nxt_s  = HOLD_ZERO;
         end
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         cnt_r     <= CNT_ZERO;
         hold_r    <= HOLD_ZERO;
         level_r   <= 1'b0;
         press_r   <= 1'b0;
         release_r <= 1'b0;
         long_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         hold_r    <= hold_nxt_s;
         level_r   <= level_nxt_s;
         press_r   <= press_nxt_s;
         release_r <= release_nxt_s;
         long_r    <= long_nxt_s;
      end
   end

   assign level_o   = level_r;
   assign press_o   = press_r;
   assign release_o = release_r;
   assign long_o    = long_r;

endmodule

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
// Directed test-plan scenarios plus randomised pin activity, all compared
// cycle by cycle against a behavioural model: the FSM sees the pin three
// edges late, a change is accepted after STABLE+1 consecutive opposite
// samples, and long fires LONG-STABLE edges after an accepted press.
// -----------------------------------------------------------------------------
module tb_btn_debounce;

   localparam int STABLE = 4;
   localparam int LONG   = 20;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic btn_i = 1'b1;
   logic level_o;
   logic press_o;
   logic release_o;
   logic long_o;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // model state
   logic [2:0] m_hist;
   logic       m_level;
   int         m_run;
   int         m_age;
   logic       m_long_done;
   logic       e_press;
   logic       e_release;
   logic       e_long;

   // observed pulse statistics for the directed scenarios
   int n_press, n_rel, n_long;
   int last_press, last_rel, last_long;

   btn_debounce #(
      .ACTIVE_LOW    (1'b1),
      .STABLE_CYCLES (STABLE),
      .LONG_CYCLES   (LONG)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_i     (btn_i),
      .level_o   (level_o),
      .press_o   (press_o),
      .release_o (release_o),
      .long_o    (long_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      m_hist      = 3'b111;
      m_level     = 1'b0;
      m_run       = 0;
      m_age       = 0;
      m_long_done = 1'b0;
      e_press     = 1'b0;
      e_release   = 1'b0;
      e_long      = 1'b0;
   endtask

   task automatic model_edge();
      logic s;
      logic toggle;
      s         = ~m_hist[2];
      e_press   = 1'b0;
      e_release = 1'b0;
      e_long    = 1'b0;
      if (s != m_level) m_run++;
      else m_run = 0;
      toggle = (m_run == STABLE + 1);
      if (m_level) begin
         m_age++;
         if (toggle) begin
            e_release = 1'b1;
            m_level   = 1'b0;
            m_run     = 0;
            m_age     = 0;
         end else if (m_age == LONG - STABLE && !m_long_done) begin
            e_long      = 1'b1;
            m_long_done = 1'b1;
         end
      end else if (toggle) begin
         e_press     = 1'b1;
         m_level     = 1'b1;
         m_run       = 0;
         m_age       = 0;
         m_long_done = 1'b0;
      end
      m_hist = {m_hist[1:0], btn_i};
   endtask

   task automatic clear_stats();
      n_press = 0; n_rel = 0; n_long = 0;
      last_press = -1; last_rel = -1; last_long = -1;
   endtask

   // one clock: drive at negedge, model at posedge, compare at next negedge
   task automatic step(input logic pin);
      cyc++;
      btn_i = pin;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("level",   level_o,   m_level);
      check("press",   press_o,   e_press);
      check("release", release_o, e_release);
      check("long",    long_o,    e_long);
      if (press_o)   begin n_press++; last_press = cyc; end
      if (release_o) begin n_rel++;   last_rel   = cyc; end
      if (long_o)    begin n_long++;  last_long  = cyc; end
   endtask

   // async reset applied between edges; outputs must drop with no clock
   task automatic do_reset(input int cycles);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_level",   level_o,   1'b0);
      check("rst_press",   press_o,   1'b0);
      check("rst_release", release_o, 1'b0);
      check("rst_long",    long_o,    1'b0);
      model_reset();
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int t0;
      logic v;
      model_reset();
      clear_stats();
      @(negedge clk);
      do_reset(2);
      repeat (10) step(1'b1);

      // clean press, long press and clean release
      clear_stats();
      t0 = cyc + 1;
      repeat (12) step(1'b0);
      check("clean_press_cnt", n_press, 1);
      check("clean_press_lat", last_press - t0, 7);
      check("clean_level", level_o, 1'b1);
      repeat (30) step(1'b0);
      check("long_cnt", n_long, 1);
      check("long_lat", last_long - last_press, LONG - STABLE);
      t0 = cyc + 1;
      repeat (12) step(1'b1);
      check("release_cnt", n_rel, 1);
      check("release_lat", last_rel - t0, 7);
      check("release_level", level_o, 1'b0);

      // bouncy press
      clear_stats();
      for (int i = 0; i < 12; i++) step(((i / 2) % 2) == 1);
      t0 = cyc + 1;
      repeat (12) step(1'b0);
      check("bounce_press_cnt", n_press, 1);
      check("bounce_press_lat", last_press - t0, 7);
      repeat (12) step(1'b1);

      // short glitch is rejected
      clear_stats();
      repeat (3) step(1'b0);
      repeat (10) step(1'b1);
      check("glitch_press_cnt", n_press, 0);
      check("glitch_rel_cnt", n_rel, 0);
      check("glitch_level", level_o, 1'b0);

      // release bounce while pressed
      clear_stats();
      repeat (10) step(1'b0);
      repeat (2) step(1'b1);
      repeat (10) step(1'b0);
      check("rbounce_press_cnt", n_press, 1);
      check("rbounce_rel_cnt", n_rel, 0);
      check("rbounce_level", level_o, 1'b1);

      // reset while pressed, button still held afterwards
      do_reset(3);
      clear_stats();
      t0 = cyc + 1;
      repeat (10) step(1'b0);
      check("rstheld_press_cnt", n_press, 1);
      check("rstheld_press_lat", last_press - t0, 7);
      check("rstheld_rel_cnt", n_rel, 0);
      repeat (12) step(1'b1);

      // randomised pin activity with occasional resets
      v = 1'b1;
      for (int r = 0; r < 300; r++) begin
         int len;
         v = ~v;
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 8);
         for (int k = 0; k < len; k++) step(v);
         if ($urandom_range(0, 59) == 0) do_reset($urandom_range(1, 4));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
